mat_drain: RTL and testbench

Result-side reader for the element-wise matrix datapath. It captures a full `rsize`×`csize` matrix of 32-bit words when the upstream block signals completion, then streams the elements out one per handshake in row-major order over a valid/ready interface. It sits between the matrix adder's parallel `result`/`done` outputs and any word-serial consumer, such as a host FIFO or a write-back engine.

---
 rtl/mat_pkg.sv | 16 +
 rtl/mat_drain.sv | 109 ++++++++++
 tb/tb_mat_drain.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared types and helpers for the element-wise matrix datapath blocks.
package mat_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE,
        SEND
    } drain_state_t;

    // Index width for an n-entry dimension, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_drain.sv
// Captures a full matrix on producer completion and streams it out
// row-major, one word per valid/ready handshake.
module mat_drain
    import mat_pkg::*;
#(
    parameter int rsize = 2,
    parameter int csize = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [rsize-1:0][csize-1:0][31:0]      mat,
    input  logic                                   mat_valid,
    output logic                                   busy,
    output logic [31:0]                            out_data,
    output logic [idx_width(rsize)-1:0]            out_row,
    output logic [idx_width(csize)-1:0]            out_col,
    output logic                                   out_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   drop
);

    localparam int RW = idx_width(rsize);
    localparam int CW = idx_width(csize);
    localparam logic [RW-1:0] ROW_MAX = RW'(rsize - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(csize - 1);

    drain_state_t state_q, state_d;
    word_t [rsize-1:0][csize-1:0] snap_q, snap_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic drop_q, drop_d;

    logic sending;
    logic at_last;
    logic xfer;

    assign sending = (state_q == SEND);
    assign at_last = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign xfer    = sending && out_ready;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        row_d   = row_q;
        col_d   = col_q;
        drop_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mat_valid) begin
                    snap_d  = mat;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer && at_last) begin
                    row_d = '0;
                    col_d = '0;
                    // A matrix arriving on the final beat chains straight on.
                    if (mat_valid) begin
                        snap_d = mat;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                if (mat_valid && !(xfer && at_last)) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            row_q   <= row_d;
            col_q   <= col_d;
            drop_q  <= drop_d;
        end
    end

    // Everything the consumer sees is decoded from registered state only.
    assign busy      = sending;
    assign out_valid = sending;
    assign out_last  = sending && at_last;
    assign out_data  = snap_q[row_q][col_q];
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_mat_drain.sv
// Scoreboard bench for mat_drain: a matrix-level model predicts beats and
// drops, a negedge monitor compares them against the DUT.
module tb_mat_drain;

    localparam int R = 2;
    localparam int C = 3;
    localparam int N = R * C;

    typedef logic [R-1:0][C-1:0][31:0] mat_t;

    typedef struct {
        logic [31:0] data;
        int          row;
        int          col;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    mat_t        mat;
    logic        mat_valid;
    logic        busy;
    logic [31:0] out_data;
    logic [0:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        drop;

    int    assertCount = 0;
    int    failCount   = 0;
    int    xferCount   = 0;
    int    remBeats    = 0;
    logic  dropExp     = 1'b0;
    beat_t expQ[$];

    mat_t matA;
    mat_t matB;
    mat_t matFF;

    mat_drain #(.rsize(R), .csize(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mat       (mat),
        .mat_valid (mat_valid),
        .busy      (busy),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are applied now and held across the next rising edge.
    task automatic applyStimulus(input mat_t m, input logic v, input logic rdy);
        mat       = m;
        mat_valid = v;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input mat_t m, input bit backpressure);
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            if (remBeats == 0) begin
                done = 1;
                break;
            end
            applyStimulus(m, 1'b0, backpressure ? (i % 3 == 0) : 1'b1);
        end
        checkOutput("drain_timeout", 32'(done), 32'd1);
    endtask

    task automatic stepUntilRemaining(input mat_t m, input int target);
        bit hit = 0;
        for (int i = 0; i < 50; i++) begin
            if (remBeats == target) begin
                hit = 1;
                break;
            end
            applyStimulus(m, 1'b0, 1'b1);
        end
        checkOutput("step_timeout", 32'(hit), 32'd1);
    endtask

    // Reference model: a matrix is accepted when nothing is pending or the
    // final beat is leaving this cycle; otherwise it is reported as a drop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remBeats = 0;
            dropExp  = 1'b0;
            expQ.delete();
        end else begin
            automatic bit xfer   = (remBeats > 0) && out_ready;
            automatic bit finish = xfer && (remBeats == 1);
            automatic bit accept = mat_valid && ((remBeats == 0) || finish);
            if (xfer) remBeats = remBeats - 1;
            dropExp = mat_valid && !accept;
            if (accept) begin
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++)
                        expQ.push_back('{mat[r][c], r, c, (r == R - 1) && (c == C - 1)});
                remBeats = N;
            end
        end
    end

    // Monitor: the head of the queue must be presented on every valid
    // cycle, and it is retired only when the consumer takes it.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("busy", 32'(busy), 32'(remBeats > 0));
            checkOutput("out_valid", 32'(out_valid), 32'(remBeats > 0));
            checkOutput("drop", 32'(drop), 32'(dropExp));
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(expQ.size()), 32'd1);
                end else begin
                    checkOutput("out_data", out_data, expQ[0].data);
                    checkOutput("out_row", 32'(out_row), 32'(expQ[0].row));
                    checkOutput("out_col", 32'(out_col), 32'(expQ[0].col));
                    checkOutput("out_last", 32'(out_last), 32'(expQ[0].last));
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        xferCount++;
                    end
                end
            end else begin
                checkOutput("out_last_idle", 32'(out_last), 32'd0);
            end
        end
    end

    initial begin
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                matA[r][c]  = 32'(r * C + c + 1);
                matB[r][c]  = 32'(r * C + c + 7);
                matFF[r][c] = 32'hFFFF_FFFF;
            end
        end

        rst_n     = 1'b0;
        mat       = '0;
        mat_valid = 1'b0;
        out_ready = 1'b0;
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_drop", 32'(drop), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_row", 32'(out_row), 32'd0);
        checkOutput("rst_out_col", 32'(out_col), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus('0, 1'b0, 1'b1);

        $display("[TB] single matrix, ready high");
        xferCount = 0;
        applyStimulus(matA, 1'b1, 1'b1);
        waitDrain(matA, 1'b0);
        applyStimulus(matA, 1'b0, 1'b1);
        checkOutput("single_count", 32'(xferCount), 32'd6);

        $display("[TB] backpressure");
        xferCount = 0;
        applyStimulus(matA, 1'b1, 1'b1);
        waitDrain(matA, 1'b1);
        applyStimulus(matA, 1'b0, 1'b1);
        checkOutput("bp_count", 32'(xferCount), 32'd6);

        $display("[TB] snapshot isolation");
        xferCount = 0;
        applyStimulus(matA, 1'b1, 1'b1);
        waitDrain(matFF, 1'b0);
        applyStimulus(matFF, 1'b0, 1'b1);
        checkOutput("iso_count", 32'(xferCount), 32'd6);

        $display("[TB] back-to-back");
        xferCount = 0;
        applyStimulus(matA, 1'b1, 1'b1);
        stepUntilRemaining(matA, 1);
        applyStimulus(matB, 1'b1, 1'b1);
        checkOutput("b2b_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_first", out_data, 32'd7);
        waitDrain(matB, 1'b0);
        applyStimulus(matB, 1'b0, 1'b1);
        checkOutput("b2b_count", 32'(xferCount), 32'd12);

        $display("[TB] overflow");
        xferCount = 0;
        applyStimulus(matA, 1'b1, 1'b1);
        stepUntilRemaining(matA, 4);
        applyStimulus(matB, 1'b1, 1'b1);
        checkOutput("ovf_drop", 32'(drop), 32'd1);
        waitDrain(matA, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(matA, 1'b0, 1'b1);
        checkOutput("ovf_count", 32'(xferCount), 32'd6);

        $display("[TB] async reset mid-burst");
        applyStimulus(matA, 1'b1, 1'b1);
        stepUntilRemaining(matA, 4);
        mat_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(matA, 1'b0, 1'b1);
        checkOutput("arst_no_resume", 32'(out_valid), 32'd0);
        xferCount = 0;
        applyStimulus(matB, 1'b1, 1'b1);
        checkOutput("arst_restart_row", 32'(out_row), 32'd0);
        checkOutput("arst_restart_col", 32'(out_col), 32'd0);
        waitDrain(matB, 1'b0);
        applyStimulus(matB, 1'b0, 1'b1);
        checkOutput("arst_count", 32'(xferCount), 32'd6);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            mat_t m;
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    m[r][c] = $urandom;
            applyStimulus(m, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        waitDrain(matA, 1'b0);
        applyStimulus(matA, 1'b0, 1'b1);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
